prach_idft3: RTL and testbench

- Streaming inverse 3-point DFT for the PRACH generation (transmit) path; the counterpart to the forward DFT-3 in the receive path.
- Groups incoming complex samples into frames of 3 (x0, x1, x2), computes y[k] = sum x[n]·e^{+j2πnk/3}, then emits y0, y1, y2 on 3 consecutive cycles.
- Sits after subcarrier mapping and before the upsampling chain.

---
 rtl/prach_pkg.sv | 30 +++
 rtl/prach_idft3_core.sv | 96 +++++++++
 rtl/prach_idft3.sv | 152 +++++++++++++++
 tb/tb_prach_idft3.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/prach_pkg.sv
// Shared PRACH types and constants used by the transmit-path IDFT-3.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prach_pkg;

    // One complex Q1.17 sample.
    typedef struct packed {
        logic signed [17:0] re;
        logic signed [17:0] im;
    } cplx18_t;

    // round(sqrt(3)/2 * 2^17)
    localparam logic signed [17:0] SQRT3_2_Q17 = 18'sd113512;

    // Rising edges from accepting x2 to the edge that presents y0.
    localparam int IDFT3_LATENCY = 3;

    // Full-precision accumulator width. The largest term is about
    // 3 * 2^17 * 2^17, so 40 bits leaves plenty of headroom.
    localparam int ACC_W = 40;

    // Input collector states.
    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        C0        = 2'd1,
        C1        = 2'd2,
        C2        = 2'd3
    } coll_state_t;

endpackage

// File: rtl/prach_idft3_core.sv
// Two-stage registered inverse DFT-3 butterfly: sums/differences, then constant multiply, round, reduce.
// Latency: 2 cycles from start to done; results hold until the next done.
// Backpressure: none; a new start may arrive every 3 cycles at most.
//
// Ports: clk, rst (sync, active high), start + x0/x1/x2 in; done + y0/y1/y2 out.
// Macro PRACH_IDFT3_SAT_EN: outputs saturate to 18 bits; otherwise they wrap.
module prach_idft3_core
    import prach_pkg::*;
#(
    parameter int SCALE_SHIFT = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  cplx18_t x0,
    input  cplx18_t x1,
    input  cplx18_t x2,
    output logic    done,
    output cplx18_t y0,
    output cplx18_t y1,
    output cplx18_t y2
);

    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (16 + SCALE_SHIFT);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(131071);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(131072);

    // Round half up at bit 17+SCALE_SHIFT, then bring back to 18 bits.
    function automatic logic signed [17:0] reduce(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        r = (v + RND) >>> (17 + SCALE_SHIFT);
`ifdef PRACH_IDFT3_SAT_EN
        if (r > SAT_MAX) begin
            return SAT_MAX[17:0];
        end else if (r < SAT_MIN) begin
            return SAT_MIN[17:0];
        end
`endif
        return r[17:0];
    endfunction

    // Stage 1: x0 delayed, t = x1 + x2, d = x1 - x2 (19 bit, exact).
    cplx18_t            x0_q;
    logic signed [18:0] t_re, t_im, d_re, d_im;
    logic               s1_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= start;
        end
        if (start) begin
            x0_q <= x0;
            t_re <= 19'(x1.re) + 19'(x2.re);
            t_im <= 19'(x1.im) + 19'(x2.im);
            d_re <= 19'(x1.re) - 19'(x2.re);
            d_im <= 19'(x1.im) - 19'(x2.im);
        end
    end

    // Stage 2 combinational terms at full precision (scaled by 2^17).
    logic signed [ACC_W-1:0] a_re, a_im, s0_re, s0_im, cd_re, cd_im;
    logic signed [ACC_W-1:0] s1_re, s1_im, s2_re, s2_im;

    always_comb begin
        a_re  = (ACC_W'(x0_q.re) <<< 17) - (ACC_W'(t_re) <<< 16);
        a_im  = (ACC_W'(x0_q.im) <<< 17) - (ACC_W'(t_im) <<< 16);
        s0_re = (ACC_W'(x0_q.re) + ACC_W'(t_re)) <<< 17;
        s0_im = (ACC_W'(x0_q.im) + ACC_W'(t_im)) <<< 17;
        cd_re = ACC_W'(SQRT3_2_Q17) * ACC_W'(d_re);
        cd_im = ACC_W'(SQRT3_2_Q17) * ACC_W'(d_im);
        // j*C*d = (-C*d_im, C*d_re)
        s1_re = a_re - cd_im;
        s1_im = a_im + cd_re;
        s2_re = a_re + cd_im;
        s2_im = a_im - cd_re;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            y0   <= '0;
            y1   <= '0;
            y2   <= '0;
        end else begin
            done <= s1_vld;
            if (s1_vld) begin
                y0 <= '{re: reduce(s0_re), im: reduce(s0_im)};
                y1 <= '{re: reduce(s1_re), im: reduce(s1_im)};
                y2 <= '{re: reduce(s2_re), im: reduce(s2_im)};
            end
        end
    end

endmodule

// File: rtl/prach_idft3.sv
// Streaming inverse DFT-3: groups input samples in threes and emits y0, y1, y2 back to back.
// Latency: y0 presented after the 3rd rising edge following acceptance of x2; y1, y2 on the next two cycles.
// Backpressure: none; input is accepted whenever din_dv=1 and frames are at least 3 samples apart.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   din_dr/din_di       input sample, signed Q1.17;  din_dv valid;  sync_in frame start (with din_dv)
//   dout_dr/dout_di     output sample, signed Q1.17 (0 when idle);  dout_dv valid;  sync_out with y0
// Parameter SCALE_SHIFT (0..2): extra output right shift.
// Macro PRACH_IDFT3_SAT_EN: saturate outputs instead of wrapping.
module prach_idft3
    import prach_pkg::*;
#(
    parameter int SCALE_SHIFT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] din_dr,
    input  logic [17:0] din_di,
    input  logic        din_dv,
    input  logic        sync_in,
    output logic [17:0] dout_dr,
    output logic [17:0] dout_di,
    output logic        dout_dv,
    output logic        sync_out
);

    // Collector FSM
    coll_state_t state, state_nxt;
    logic        cap0, cap1, cap2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cap0      = 1'b0;
        cap1      = 1'b0;
        cap2      = 1'b0;
        if (din_dv) begin
            unique case (state)
                WAIT_SYNC: begin
                    if (sync_in) begin
                        cap0      = 1'b1;
                        state_nxt = C1;
                    end
                end
                C0: begin
                    cap0      = 1'b1;
                    state_nxt = C1;
                end
                C1, C2: begin
                    if (sync_in) begin
                        // Resync: drop the partial frame, this sample is the new x0.
                        cap0      = 1'b1;
                        state_nxt = C1;
                    end else if (state == C1) begin
                        cap1      = 1'b1;
                        state_nxt = C2;
                    end else begin
                        cap2      = 1'b1;
                        state_nxt = C0;
                    end
                end
                default: state_nxt = WAIT_SYNC;
            endcase
        end
    end

    // Sample registers. x0/x1 may be overwritten by the next frame on the
    // edge after start; the core samples them on that same edge.
    cplx18_t x0_r, x1_r, x2_r;
    logic    start_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_r <= 1'b0;
        end else begin
            start_r <= cap2;
        end
        if (cap0) x0_r <= '{re: din_dr, im: din_di};
        if (cap1) x1_r <= '{re: din_dr, im: din_di};
        if (cap2) x2_r <= '{re: din_dr, im: din_di};
    end

    cplx18_t y0, y1, y2;
    logic    done;

    prach_idft3_core #(
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start_r),
        .x0    (x0_r),
        .x1    (x1_r),
        .x2    (x2_r),
        .done  (done),
        .y0    (y0),
        .y1    (y1),
        .y2    (y2)
    );

    // Output serializer. phase = index of the next result to emit (1 or 2),
    // 0 when idle. The core's next results land on the same edge that emits
    // y2 at the earliest, so reading y1/y2 straight from the core is safe.
    logic [1:0] phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= 2'd0;
            dout_dr  <= '0;
            dout_di  <= '0;
            dout_dv  <= 1'b0;
            sync_out <= 1'b0;
        end else if (done) begin
            phase    <= 2'd1;
            dout_dr  <= y0.re;
            dout_di  <= y0.im;
            dout_dv  <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            sync_out <= 1'b0;
            unique case (phase)
                2'd1: begin
                    phase   <= 2'd2;
                    dout_dr <= y1.re;
                    dout_di <= y1.im;
                    dout_dv <= 1'b1;
                end
                2'd2: begin
                    phase   <= 2'd0;
                    dout_dr <= y2.re;
                    dout_di <= y2.im;
                    dout_dv <= 1'b1;
                end
                default: begin
                    phase   <= 2'd0;
                    dout_dr <= '0;
                    dout_di <= '0;
                    dout_dv <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prach_idft3.sv
// Directed bench for prach_idft3 with hand-computed expectations.
// Two instances share the input stream: SCALE_SHIFT=1 and SCALE_SHIFT=0.
// Define PRACH_IDFT3_SAT_EN to build and check the saturating variant.
module tb_prach_idft3;
    import prach_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [17:0] din_dr, din_di;
    logic               din_dv, sync_in;

    logic signed [17:0] dout_dr, dout_di, dout0_dr, dout0_di;
    logic               dout_dv, sync_out, dout0_dv, sync0_out;

    prach_idft3 #(.SCALE_SHIFT(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .din_dr   (din_dr),
        .din_di   (din_di),
        .din_dv   (din_dv),
        .sync_in  (sync_in),
        .dout_dr  (dout_dr),
        .dout_di  (dout_di),
        .dout_dv  (dout_dv),
        .sync_out (sync_out)
    );

    prach_idft3 #(.SCALE_SHIFT(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .din_dr   (din_dr),
        .din_di   (din_di),
        .din_dv   (din_dv),
        .sync_in  (sync_in),
        .dout_dr  (dout0_dr),
        .dout_di  (dout0_di),
        .dout_dv  (dout0_dv),
        .sync_out (sync0_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int edge_n = 0;
    int last_edge;

    // Captured outputs per instance: value, sync flag and producing edge.
    int q1_re[$], q1_im[$], q1_sy[$], q1_ed[$];
    int q0_re[$], q0_im[$], q0_sy[$], q0_ed[$];

    initial begin
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            #1;
            if (dout_dv) begin
                q1_re.push_back(int'(dout_dr));
                q1_im.push_back(int'(dout_di));
                q1_sy.push_back(int'(sync_out));
                q1_ed.push_back(edge_n);
            end
            if (dout0_dv) begin
                q0_re.push_back(int'(dout0_dr));
                q0_im.push_back(int'(dout0_di));
                q0_sy.push_back(int'(sync0_out));
                q0_ed.push_back(edge_n);
            end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic send(input int re, input int im, input logic sy);
        @(negedge clk);
        din_dr    = 18'(re);
        din_di    = 18'(im);
        din_dv    = 1'b1;
        sync_in   = sy;
        last_edge = edge_n + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din_dv  = 1'b0;
            sync_in = 1'b0;
            din_dr  = 18'h2AAAA;
            din_di  = 18'h15555;
        end
    endtask

    function automatic int qsize(input int which);
        return (which == 0) ? q0_re.size() : q1_re.size();
    endfunction

    // Pops one frame from the chosen queue and checks values, sync_out and
    // the edge each output appeared on (y0 at t_edge+IDFT3_LATENCY, contiguous).
    task automatic check_frame(input string tag, input int which, input int t_edge,
                               input int e0r, input int e0i, input int e1r,
                               input int e1i, input int e2r, input int e2i);
        int er[3], ei[3];
        int re, im, sy, ed;
        er = '{e0r, e1r, e2r};
        ei = '{e0i, e1i, e2i};
        for (int i = 0; i < 40 && qsize(which) < 3; i++) @(negedge clk);
        check({tag, ".count"}, (qsize(which) >= 3) ? 3 : qsize(which), 3);
        if (qsize(which) < 3) return;
        for (int k = 0; k < 3; k++) begin
            if (which == 0) begin
                re = q0_re.pop_front(); im = q0_im.pop_front();
                sy = q0_sy.pop_front(); ed = q0_ed.pop_front();
            end else begin
                re = q1_re.pop_front(); im = q1_im.pop_front();
                sy = q1_sy.pop_front(); ed = q1_ed.pop_front();
            end
            check($sformatf("%s.y%0d.re", tag, k), re, er[k]);
            check($sformatf("%s.y%0d.im", tag, k), im, ei[k]);
            check($sformatf("%s.y%0d.sync", tag, k), sy, (k == 0) ? 1 : 0);
            check($sformatf("%s.y%0d.edge", tag, k), ed, t_edge + IDFT3_LATENCY + k);
        end
    endtask

    int t1, t2;
    int ovf_exp;

    initial begin
        rst = 1'b1; din_dv = 1'b0; sync_in = 1'b0; din_dr = '0; din_di = '0;
`ifdef PRACH_IDFT3_SAT_EN
        ovf_exp = 131071;
`else
        ovf_exp = 131069;
`endif
        // Traffic during reset must be ignored.
        send(777, 888, 1'b1);
        send(1, 2, 1'b0);
        send(3, 4, 1'b0);
        idle(2);
        check("rst.dv",   int'(dout_dv),  0);
        check("rst.dr",   int'(dout_dr),  0);
        check("rst.di",   int'(dout_di),  0);
        check("rst.sync", int'(sync_out), 0);
        @(negedge clk); rst = 1'b0;
        idle(8);
        check("rst.no_out", qsize(1), 0);

        // Samples before the first sync are dropped.
        send(5, 5, 1'b0); send(7, 7, 1'b0);
        idle(8);
        check("pre_sync.no_out", qsize(1), 0);

        // Impulse
        send(1000, 0, 1'b1); send(0, 0, 1'b0); send(0, 0, 1'b0);
        t1 = last_edge; idle(1);
        check_frame("impulse", 1, t1, 500, 0, 500, 0, 500, 0);
        idle(4);

        // DC, no sync: grouping continues from C0.
        send(1000, 0, 1'b0); send(1000, 0, 1'b0); send(1000, 0, 1'b0);
        t1 = last_edge; idle(1);
        check_frame("dc", 1, t1, 1500, 0, 0, 0, 0, 0);
        idle(4);

        // Rotation
        send(0, 0, 1'b1); send(1000, 0, 1'b0); send(0, 0, 1'b0);
        t1 = last_edge; idle(1);
        check_frame("rot", 1, t1, 500, 0, -250, 433, -250, -433);
        idle(4);

        // Back-to-back frames: outputs must be contiguous.
        send(0, 0, 1'b1); send(1000, 0, 1'b0); send(0, 0, 1'b0);
        t1 = last_edge;
        send(1000, 0, 1'b0); send(1000, 0, 1'b0); send(1000, 0, 1'b0);
        t2 = last_edge; idle(1);
        check_frame("b2b.rot", 1, t1, 500, 0, -250, 433, -250, -433);
        check_frame("b2b.dc",  1, t2, 1500, 0, 0, 0, 0, 0);
        idle(4);

        // Gaps between input samples.
        send(1000, 0, 1'b1); idle(2); send(0, 0, 1'b0); idle(3); send(0, 0, 1'b0);
        t1 = last_edge; idle(1);
        check_frame("gaps", 1, t1, 500, 0, 500, 0, 500, 0);
        idle(4);

        // Resync on the 2nd sample: the partial frame is discarded.
        send(111, 222, 1'b1); send(1000, 0, 1'b1); send(0, 0, 1'b0); send(0, 0, 1'b0);
        t1 = last_edge; idle(1);
        check_frame("resync", 1, t1, 500, 0, 500, 0, 500, 0);
        idle(8);
        check("resync.no_extra", qsize(1), 0);

        // Overflow with SCALE_SHIFT=0.
        q0_re.delete(); q0_im.delete(); q0_sy.delete(); q0_ed.delete();
        send(131071, 0, 1'b1); send(131071, 0, 1'b0); send(131071, 0, 1'b0);
        t1 = last_edge; idle(1);
        check_frame("ovf", 0, t1, ovf_exp, 0, 0, 0, 0, 0);
        idle(4);
        q1_re.delete(); q1_im.delete(); q1_sy.delete(); q1_ed.delete();

        // Reset while y1 is on the output.
        send(1000, 0, 1'b1); send(0, 0, 1'b0); send(0, 0, 1'b0);
        t1 = last_edge;
        @(negedge clk); din_dv = 1'b0; sync_in = 1'b0;
        for (int i = 0; i < 20 && edge_n < t1 + 4; i++) @(negedge clk);
        check("rst_mid.y1_dv", int'(dout_dv), 1);
        check("rst_mid.y1_re", int'(dout_dr), 500);
        check("rst_mid.y1_sync", int'(sync_out), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid.dv_next", int'(dout_dv), 0);
        rst = 1'b0;
        idle(8);
        check("rst_mid.count", qsize(1), 2);
        if (qsize(1) > 0) check("rst_mid.y0_edge", q1_ed[0], t1 + IDFT3_LATENCY);
        q1_re.delete(); q1_im.delete(); q1_sy.delete(); q1_ed.delete();

        // After reset, samples without sync are dropped again.
        send(1000, 0, 1'b0); send(1000, 0, 1'b0); send(1000, 0, 1'b0);
        idle(8);
        check("rst_mid.drop", qsize(1), 0);

        // And a synced frame works normally.
        send(0, 0, 1'b1); send(1000, 0, 1'b0); send(0, 0, 1'b0);
        t1 = last_edge; idle(1);
        check_frame("recover", 1, t1, 500, 0, -250, 433, -250, -433);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
